// File: rtl/svm_model_sender_if.sv
// Bundles the start/config inputs, the coefficient read port and the byte stream of svm_model_sender.
// The master modport is the sender's view; the slave modport is the host, memory and sink view.
interface svm_model_sender_if #(
    parameter int NUM_FEATURES_IN = 16
) ();
    localparam int CW = $clog2(NUM_FEATURES_IN);

    logic              start_in;
    logic [7:0]        num_supports_in;
    logic [31:0]       offset_in;
    logic [8+CW-1:0]   coef_addr_out;
    logic [15:0]       coef_data_in;
    logic [7:0]        byte_data_out;
    logic              byte_valid_out;
    logic              byte_ready_in;
    logic              busy_out;
    logic              done_out;
    logic              error_out;

    modport master (
        input  start_in, num_supports_in, offset_in, coef_data_in, byte_ready_in,
        output coef_addr_out, byte_data_out, byte_valid_out, busy_out, done_out, error_out
    );

    modport slave (
        output start_in, num_supports_in, offset_in, coef_data_in, byte_ready_in,
        input  coef_addr_out, byte_data_out, byte_valid_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/svm_model_sender.sv
// Streams N, every coefficient except index 0 of each support vector, then the offset,
// as MSB-first bytes over a valid/ready interface, fetching coefficients from an external memory.
module svm_model_sender #(
    parameter int NUM_FEATURES_IN = 16,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    svm_model_sender_if.master    bus
);
    localparam int CW = $clog2(NUM_FEATURES_IN);
    localparam int LW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_N, FETCH, SEND_HI, SEND_LO, SEND_OFF, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [31:0]     off_q, off_d;
    logic [7:0]      vec_q, vec_d;
    logic [CW-1:0]   coef_idx_q, coef_idx_d;
    logic [15:0]     coef_q, coef_d;
    logic [LW-1:0]   wait_q, wait_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            error_q, error_d;

    function automatic logic [7:0] off_byte(input logic [31:0] off, input logic [1:0] idx);
        case (idx)
            2'd0:    off_byte = off[31:24];
            2'd1:    off_byte = off[23:16];
            2'd2:    off_byte = off[15:8];
            default: off_byte = off[7:0];
        endcase
    endfunction

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            n_q        <= '0;
            off_q      <= '0;
            vec_q      <= '0;
            coef_idx_q <= '0;
            coef_q     <= '0;
            wait_q     <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            off_q      <= off_d;
            vec_q      <= vec_d;
            coef_idx_q <= coef_idx_d;
            coef_q     <= coef_d;
            wait_q     <= wait_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            error_q    <= error_d;
        end
    end

    // Each SEND_* state first loads its byte (valid rises a cycle after entry),
    // then holds it until the sink accepts it.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        off_d      = off_q;
        vec_d      = vec_q;
        coef_idx_d = coef_idx_q;
        coef_d     = coef_q;
        wait_d     = wait_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = valid_q;
        data_d     = data_q;
        error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    if (bus.num_supports_in == 8'd0) begin
                        error_d = 1'b1;
                    end else begin
                        n_d        = bus.num_supports_in;
                        off_d      = bus.offset_in;
                        vec_d      = 8'd0;
                        coef_idx_d = CW'(1);
                        state_d    = SEND_N;
                    end
                end
            end
            SEND_N: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = n_q;
                end else if (bus.byte_ready_in) begin
                    valid_d = 1'b0;
                    wait_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Address has been stable since entry; data is good once the latency has elapsed.
                if (wait_q == LW'(MEM_LATENCY)) begin
                    coef_d  = bus.coef_data_in;
                    state_d = SEND_HI;
                end else begin
                    wait_d = wait_q + LW'(1);
                end
            end
            SEND_HI: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = coef_q[15:8];
                end else if (bus.byte_ready_in) begin
                    valid_d = 1'b0;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = coef_q[7:0];
                end else if (bus.byte_ready_in) begin
                    valid_d = 1'b0;
                    wait_d  = '0;
                    if (coef_idx_q < CW'(NUM_FEATURES_IN - 1)) begin
                        coef_idx_d = coef_idx_q + CW'(1);
                        state_d    = FETCH;
                    end else if (vec_q != n_q - 8'd1) begin
                        vec_d      = vec_q + 8'd1;
                        coef_idx_d = CW'(1);
                        state_d    = FETCH;
                    end else begin
                        byte_cnt_d = 2'd0;
                        state_d    = SEND_OFF;
                    end
                end
            end
            SEND_OFF: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = off_byte(off_q, byte_cnt_q);
                end else if (bus.byte_ready_in) begin
                    if (byte_cnt_q == 2'd3) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        data_d     = off_byte(off_q, byte_cnt_q + 2'd1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.coef_addr_out  = {vec_q, coef_idx_q};
    assign bus.byte_data_out  = data_q;
    assign bus.byte_valid_out = valid_q;
    assign bus.busy_out       = (state_q != IDLE);
    assign bus.done_out       = (state_q == DONE);
    assign bus.error_out      = error_q;
endmodule

// File: tb/tb_svm_model_sender.sv
// Randomised scoreboard bench for svm_model_sender: expected byte streams are built from the
// wire-format rules and checked by an independent monitor on every accepted byte.
module tb_svm_model_sender;
    localparam int F   = 16;
    localparam int LAT = 2;
    localparam int AW  = 8 + $clog2(F);

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    svm_model_sender_if #(.NUM_FEATURES_IN(F)) bus ();

    svm_model_sender #(.NUM_FEATURES_IN(F), .MEM_LATENCY(LAT)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Coefficient memory with a fixed read latency.
    logic [15:0]   mem [1 << AW];
    logic [AW-1:0] addr_pipe [LAT];
    always @(posedge clk) begin
        addr_pipe[0] <= bus.coef_addr_out;
        for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign bus.coef_data_in = mem[addr_pipe[LAT-1]];

    int   total = 0;
    int   bad = 0;
    int   popped = 0;
    int   done_cnt = 0;
    bit   rand_ready = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        #1;
        bus.byte_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: a byte transfers at the next rising edge when valid && ready here.
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data;
    always @(negedge clk) begin
        if (rst_in === 1'b1) begin
            if (stall_prev) begin
                total++;
                if (!(bus.byte_valid_out === 1'b1 && bus.byte_data_out === stall_data)) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%02h, need valid=1 data=%02h",
                             bus.byte_valid_out, bus.byte_data_out, stall_data);
                end
            end
            if (bus.byte_valid_out === 1'b1 && bus.byte_ready_in === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %02h, none expected", bus.byte_data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.byte_data_out !== e) begin
                        bad++;
                        $display("FAIL byte[%0d]: got %02h, need %02h", popped, bus.byte_data_out, e);
                    end
                    $display("byte %0d: %02h", popped, bus.byte_data_out);
                end
                popped++;
            end
            stall_prev = (bus.byte_valid_out === 1'b1) && (bus.byte_ready_in !== 1'b1);
            stall_data = bus.byte_data_out;
            if (bus.done_out === 1'b1) begin
                done_cnt++;
                total++;
                if (bus.busy_out !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_at_done: got busy=%b, need 1", bus.busy_out);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Reference stream built straight from the wire format.
    task automatic push_expected(input logic [7:0] n, input logic [31:0] off);
        exp_q.push_back(n);
        for (int v = 0; v < int'(n); v++) begin
            for (int c = 1; c < F; c++) begin
                logic [15:0] w;
                w = mem[v * F + c];
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(off >> (24 - 8 * k)));
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", name, got, need);
        end
    endtask

    task automatic pulse_start(input logic [7:0] n, input logic [31:0] off);
        @(posedge clk); #1;
        bus.start_in = 1'b1;
        bus.num_supports_in = n;
        bus.offset_in = off;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        bus.num_supports_in = $urandom;
        bus.offset_in = $urandom;
    endtask

    task automatic wait_done(input string name, input int budget, input int nbytes, input int pop0);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done_out within %0d cycles", name, budget);
        end
        repeat (6) @(posedge clk);
        check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_byte_count"}, 64'(popped - pop0), 64'(nbytes));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_idle"}, 64'(bus.busy_out), 64'd0);
        exp_q.delete();
    endtask

    task automatic fill_mem(input bit pattern);
        for (int a = 0; a < (1 << AW); a++) mem[a] = pattern ? 16'h0100 + 16'(a % F) : 16'($urandom);
    endtask

    function automatic int stream_len(input int n);
        return 1 + 2 * n * (F - 1) + 4;
    endfunction

    task automatic run(input string name, input logic [7:0] n, input logic [31:0] off, input bit rr);
        int p0;
        rand_ready = rr;
        push_expected(n, off);
        p0 = popped;
        pulse_start(n, off);
        wait_done(name, 60000, stream_len(int'(n)), p0);
        $display("%s: N=%0d offset=%08h bytes=%0d", name, n, off, popped - p0);
    endtask

    initial begin
        int p0;
        bit hit;
        rst_in = 1'b0;
        bus.start_in = 1'b0;
        bus.num_supports_in = 8'd0;
        bus.offset_in = 32'd0;
        fill_mem(1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({bus.coef_addr_out, bus.byte_data_out, bus.byte_valid_out,
                   bus.busy_out, bus.done_out, bus.error_out}), 64'd0);
        @(posedge clk); #1;
        rst_in = 1'b1;

        run("t1_n1_ready", 8'd1, 32'h12345678, 1'b0);
        run("t2_n1_random_ready", 8'd1, 32'h12345678, 1'b1);

        // N==0 is rejected with a one-cycle error pulse.
        rand_ready = 1'b0;
        p0 = popped;
        pulse_start(8'd0, 32'hDEADBEEF);
        @(negedge clk);
        check("t3_error_pulse", 64'(bus.error_out), 64'd1);
        check("t3_busy_low", 64'(bus.busy_out), 64'd0);
        @(negedge clk);
        check("t3_error_drop", 64'(bus.error_out), 64'd0);
        repeat (10) @(posedge clk);
        check("t3_no_bytes", 64'(popped - p0), 64'd0);
        $display("t3_n0: error checked");

        // Start re-pulsed mid-transfer must be ignored.
        rand_ready = 1'b1;
        push_expected(8'd1, 32'h12345678);
        p0 = popped;
        pulse_start(8'd1, 32'h12345678);
        for (int i = 0; i < 2000 && popped - p0 < 5; i++) @(posedge clk);
        pulse_start(8'd9, 32'h0);
        wait_done("t4_restart_ignored", 4000, 35, p0);

        // Reset after ten bytes abandons the transfer.
        fill_mem(1'b0);
        rand_ready = 1'b1;
        push_expected(8'd2, 32'hA5C3_0F81);
        p0 = popped;
        pulse_start(8'd2, 32'hA5C3_0F81);
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(posedge clk);
            if (popped - p0 >= 10) hit = 1'b1;
        end
        check("t5_reached_ten", 64'(hit), 64'd1);
        #1 rst_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_reset_outputs",
              64'({bus.coef_addr_out, bus.byte_data_out, bus.byte_valid_out,
                   bus.busy_out, bus.done_out, bus.error_out}), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_in = 1'b1;
        run("t5_after_reset_n2", 8'd2, 32'hA5C3_0F81, 1'b1);

        for (int t = 0; t < 4; t++) begin
            fill_mem(1'b0);
            run("t6_random", 8'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)));
        end

        fill_mem(1'b0);
        run("t7_n255", 8'd255, $urandom, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
